// File: rtl/if_fetch_stage_pkg.sv
// Shared widths, constants, FSM encoding and the IF/ID entry type for the fetch stage.
package if_fetch_stage_pkg;

  localparam int InstAddrW = 32;
  localparam int InstW     = 32;
  localparam int StallW    = 2;

  localparam logic [InstAddrW-1:0] ZeroWord  = '0;
  localparam logic [InstW-1:0]     NopInst   = '0;
  localparam logic [InstAddrW-1:0] PcStep    = 32'd4;
  localparam logic [InstAddrW-1:0] AlignMask = 32'h0000_0003;

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_RUN   = 2'd1,
    S_HOLD  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [InstAddrW-1:0] pc;
    logic [InstW-1:0]     inst;
    logic                 valid;
    logic                 in_ds;
  } if_id_t;

  // Word-align a redirect target; the two low bits carry no meaning.
  function automatic logic [InstAddrW-1:0] word_align(input logic [InstAddrW-1:0] addr);
    return addr & ~AlignMask;
  endfunction

endpackage

// File: rtl/if_fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush, bubble insertion, hold and capture, in that priority.
module if_id_reg
  import if_fetch_stage_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush_i,
  input  logic [StallW-1:0]    stall_i,
  input  logic                 fetch_en_i,
  input  logic                 squash_i,
  input  logic [InstAddrW-1:0] pc_i,
  input  logic [InstW-1:0]     inst_i,
  input  logic                 in_ds_i,
  output logic [InstAddrW-1:0] id_pc_o,
  output logic [InstW-1:0]     id_inst_o,
  output logic                 id_valid_o,
  output logic                 id_in_delay_slot_o
);

  localparam if_id_t Empty = '{pc: ZeroWord, inst: NopInst, valid: 1'b0, in_ds: 1'b0};

  if_id_t entry_d, entry_q;

  always_comb begin
    // NOTE: default assigned first so every path drives entry_d and no latch is inferred.
    entry_d = entry_q;
    if (flush_i) begin
      entry_d = Empty;
    end else if (stall_i[1] && !stall_i[0]) begin
      entry_d = Empty;
    end else if (stall_i[1]) begin
      entry_d = entry_q;
    end else if (!fetch_en_i || squash_i) begin
      entry_d = Empty;
    end else begin
      entry_d = '{pc: pc_i, inst: inst_i, valid: 1'b1, in_ds: in_ds_i};
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register updating from pre-edge values.
    if (rst) entry_q <= Empty;
    else     entry_q <= entry_d;
  end

  assign id_pc_o            = entry_q.pc;
  assign id_inst_o          = entry_q.inst;
  assign id_valid_o         = entry_q.valid;
  assign id_in_delay_slot_o = entry_q.in_ds;

endmodule

// File: rtl/if_fetch_stage.sv
// Fetch stage: PC, fetch FSM and next-PC selection feeding the IF/ID register.
// Define DELAY_SLOT_EN for MIPS delay-slot semantics; otherwise the word after a taken branch is squashed.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [InstAddrW-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [StallW-1:0]    stall_i,
  input  logic                 branch_flag_i,
  input  logic [InstAddrW-1:0] branch_target_i,
  input  logic                 flush_i,
  input  logic [InstAddrW-1:0] flush_pc_i,
  output logic                 rom_ce_o,
  output logic [InstAddrW-1:0] rom_addr_o,
  input  logic [InstW-1:0]     rom_data_i,
  output logic [InstAddrW-1:0] id_pc_o,
  output logic [InstW-1:0]     id_inst_o,
  output logic                 id_valid_o,
  output logic                 id_in_delay_slot_o
);

  fetch_state_e         state_d, state_q;
  logic [InstAddrW-1:0] pc_d, pc_q;
  logic                 fetch_en;
  logic                 branch_take;
  logic                 if_squash;
  logic                 if_in_ds;

  assign fetch_en    = (state_q != S_RESET);
  // A branch is taken only on an edge that actually moves the PC.
  assign branch_take = branch_flag_i && fetch_en && !flush_i && !stall_i[0];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RESET:       state_d = S_RUN;
      S_RUN, S_HOLD: state_d = stall_i[0] ? S_HOLD : S_RUN;
      default:       state_d = S_RESET;
    endcase
  end

  always_comb begin
    pc_d = pc_q;
    if (flush_i) begin
      pc_d = flush_pc_i;
    end else if (!fetch_en || stall_i[0]) begin
      pc_d = pc_q;
    end else if (branch_take) begin
      pc_d = word_align(branch_target_i);
    end else begin
      pc_d = pc_q + PcStep;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RESET;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

`ifdef DELAY_SLOT_EN
  assign if_squash = 1'b0;
  assign if_in_ds  = branch_take;
`else
  assign if_squash = branch_take;
  assign if_in_ds  = 1'b0;
`endif

  assign rom_ce_o   = fetch_en;
  assign rom_addr_o = pc_q;

  if_id_reg u_if_id_reg (
    .clk                (clk),
    .rst                (rst),
    .flush_i            (flush_i),
    .stall_i            (stall_i),
    .fetch_en_i         (fetch_en),
    .squash_i           (if_squash),
    .pc_i               (pc_q),
    .inst_i             (rom_data_i),
    .in_ds_i            (if_in_ds),
    .id_pc_o            (id_pc_o),
    .id_inst_o          (id_inst_o),
    .id_valid_o         (id_valid_o),
    .id_in_delay_slot_o (id_in_delay_slot_o)
  );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios then random traffic against a cycle-level reference model.
module tb_if_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef DELAY_SLOT_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  stall;
  logic        br;
  logic [31:0] br_target;
  logic        flush;
  logic [31:0] flush_pc;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_valid;
  logic        id_ds;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  // Reference model state: architectural view of PC and the IF/ID contents.
  logic [31:0] m_pc;
  logic        m_run;
  logic [31:0] m_id_pc;
  logic [31:0] m_id_inst;
  logic        m_id_valid;
  logic        m_id_ds;
  logic        m_id_known;

  always #5 clk = ~clk;

  // ROM contents: a nonzero hash of the address so bubbles and real words differ.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return ((a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F) | 32'h1;
  endfunction

  assign rom_data = rom_word(rom_addr);

  if_fetch_stage #(.RESET_PC(RESET_PC)) dut (
    .clk                (clk),
    .rst                (rst),
    .stall_i            (stall),
    .branch_flag_i      (br),
    .branch_target_i    (br_target),
    .flush_i            (flush),
    .flush_pc_i         (flush_pc),
    .rom_ce_o           (rom_ce),
    .rom_addr_o         (rom_addr),
    .rom_data_i         (rom_data),
    .id_pc_o            (id_pc),
    .id_inst_o          (id_inst),
    .id_valid_o         (id_valid),
    .id_in_delay_slot_o (id_ds)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock: predict from the current inputs, step the DUT, compare.
  task automatic tick();
    logic [31:0] n_pc, n_id_pc, n_id_inst;
    logic        n_run, n_valid, n_ds, n_known;
    bit          take;
    n_pc = m_pc; n_run = m_run; n_id_pc = m_id_pc; n_id_inst = m_id_inst;
    n_valid = m_id_valid; n_ds = m_id_ds; n_known = m_id_known;
    if (rst) begin
      n_pc = RESET_PC; n_run = 1'b0;
      n_id_pc = 32'h0; n_id_inst = 32'h0; n_valid = 1'b0; n_ds = 1'b0; n_known = 1'b1;
    end else begin
      take = br && m_run && !flush && !stall[0];
      if (flush) begin
        n_id_pc = 32'h0; n_id_inst = 32'h0; n_valid = 1'b0; n_ds = 1'b0; n_known = 1'b1;
      end else if (stall == 2'b10) begin
        n_id_inst = 32'h0; n_valid = 1'b0; n_known = 1'b0;
      end else if (stall[1]) begin
        // IF/ID holds
      end else if (!m_run || (take && !DS)) begin
        n_id_inst = 32'h0; n_valid = 1'b0; n_known = 1'b0;
      end else begin
        n_id_pc = m_pc; n_id_inst = rom_word(m_pc); n_valid = 1'b1;
        n_ds = DS && take; n_known = 1'b1;
      end
      if (flush) n_pc = flush_pc;
      else if (m_run && !stall[0]) n_pc = take ? {br_target[31:2], 2'b00} : m_pc + 32'd4;
      n_run = 1'b1;
    end
    @(posedge clk);
    #1;
    m_pc = n_pc; m_run = n_run; m_id_pc = n_id_pc; m_id_inst = n_id_inst;
    m_id_valid = n_valid; m_id_ds = n_ds; m_id_known = n_known;
    check("rom_ce", {31'b0, rom_ce}, {31'b0, m_run});
    check("rom_addr", rom_addr, m_pc);
    check("id_valid", {31'b0, id_valid}, {31'b0, m_id_valid});
    check("id_inst", id_inst, m_id_inst);
    if (m_id_known) check("id_pc", id_pc, m_id_pc);
    if (m_id_known || !DS) check("id_ds", {31'b0, id_ds}, {31'b0, m_id_ds});
  endtask

  initial begin
    logic [31:0] saved_pc, saved_id_pc;
    int guard;
    int s;
    rst = 1'b1; stall = 2'b00; br = 1'b0; br_target = 32'h0; flush = 1'b0; flush_pc = 32'h0;
    m_pc = RESET_PC; m_run = 1'b0; m_id_pc = 32'h0; m_id_inst = 32'h0;
    m_id_valid = 1'b0; m_id_ds = 1'b0; m_id_known = 1'b1;

    // Reset held for 10 cycles.
    for (int i = 0; i < 10; i++) tick();
    check("reset_ce", {31'b0, rom_ce}, 32'h0);
    check("reset_id_pc", id_pc, 32'h0);

    // Release: PC 0x0, 0x4, 0x8 with id_pc lagging by one.
    rst = 1'b0;
    tick();
    check("rel_ce", {31'b0, rom_ce}, 32'h1);
    check("rel_addr0", rom_addr, 32'h0);
    tick();
    check("rel_addr4", rom_addr, 32'h4);
    check("rel_id0", id_pc, 32'h0);
    tick();
    check("rel_addr8", rom_addr, 32'h8);
    check("rel_id4", id_pc, 32'h4);

    // Jump to 0x40 while ID holds 0x24.
    guard = 0;
    while (!(m_id_valid && m_id_pc == 32'h24) && guard < 50) begin
      tick();
      guard++;
    end
    check("reach_id_24", id_pc, 32'h24);
    br = 1'b1; br_target = 32'h40;
    tick();
    br = 1'b0;
    check("jmp_addr", rom_addr, 32'h40);
    if (DS) begin
      check("jmp_ds_pc", id_pc, 32'h28);
      check("jmp_ds_flag", {31'b0, id_ds}, 32'h1);
    end else begin
      check("jmp_bubble", {31'b0, id_valid}, 32'h0);
    end
    tick();
    check("jmp_tgt_pc", id_pc, 32'h40);
    check("jmp_tgt_ds", {31'b0, id_ds}, 32'h0);

    // Full stall freezes PC and IF/ID; stall 2'b10 inserts a bubble while PC moves.
    flush = 1'b1; flush_pc = 32'h10;
    tick();
    flush = 1'b0;
    tick();
    saved_pc = m_pc; saved_id_pc = m_id_pc;
    stall = 2'b11;
    for (int i = 0; i < 3; i++) tick();
    check("stall_pc", rom_addr, saved_pc);
    check("stall_id", id_pc, saved_id_pc);
    stall = 2'b10;
    tick();
    check("bubble_valid", {31'b0, id_valid}, 32'h0);
    check("bubble_pc_adv", rom_addr, saved_pc + 32'd4);
    stall = 2'b00;
    tick();

    // Flush beats a simultaneous branch.
    flush = 1'b1; flush_pc = 32'h20; br = 1'b1; br_target = 32'h80;
    tick();
    flush = 1'b0; br = 1'b0;
    check("flush_pc", rom_addr, 32'h20);
    check("flush_valid", {31'b0, id_valid}, 32'h0);
    check("flush_inst", id_inst, 32'h0);

    // PC wraps from 0xFFFFFFFC to 0.
    flush = 1'b1; flush_pc = 32'hFFFF_FFF8;
    tick();
    flush = 1'b0;
    tick();
    check("wrap_fffc", rom_addr, 32'hFFFF_FFFC);
    tick();
    check("wrap_zero", rom_addr, 32'h0);

    // Misaligned target is forced to a word boundary.
    br = 1'b1; br_target = 32'h43;
    tick();
    br = 1'b0;
    check("align_tgt", rom_addr, 32'h40);
    tick();

    // Reset arriving during a stall.
    stall = 2'b11;
    tick();
    rst = 1'b1;
    tick();
    check("rst_stall_ce", {31'b0, rom_ce}, 32'h0);
    check("rst_stall_addr", rom_addr, RESET_PC);
    check("rst_stall_valid", {31'b0, id_valid}, 32'h0);
    rst = 1'b0; stall = 2'b00;
    tick();
    tick();

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      rst      = ($urandom_range(0, 99) == 0);
      flush    = m_run && !rst && ($urandom_range(0, 19) == 0);
      flush_pc = $urandom & 32'hFFFF_FFFC;
      s = $urandom_range(0, 9);
      if (s < 6)       stall = 2'b00;
      else if (s < 8)  stall = 2'b11;
      else if (s == 8) stall = 2'b01;
      else             stall = 2'b10;
      br        = m_id_valid && (stall != 2'b10) && ($urandom_range(0, 3) == 0);
      br_target = $urandom;
      tick();
    end

    rst = 1'b0; flush = 1'b0; stall = 2'b00; br = 1'b0;
    tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
# if_fetch_stage

Instruction-fetch front end of the openMIPS core: owns the program counter, drives the instruction ROM, and registers fetched words into the IF/ID pipeline register consumed by the decode stage. It resolves redirects from decode (branches and jumps, including the architectural delay slot), from the pipeline controller (stall) and from exception logic (flush). It is the stage directly upstream of decode, where `j`/`jal`/`jr`/`beq` targets are computed.

## Interface
- `RESET_PC`, default `32'h00000000`: PC value loaded by reset.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `stall_i`  in  2  `[0]` holds the PC; `[1]` holds the IF/ID register.
- `branch_flag_i`  in  1  decode has resolved a taken branch or jump this cycle.
- `branch_target_i`  in  32  redirect target; bits `[1:0]` are ignored and forced to 0.
- `flush_i`  in  1  exception flush.
- `flush_pc_i`  in  32  handler address loaded on flush.
- `rom_ce_o`  out  1  ROM chip enable.
- `rom_addr_o`  out  32  ROM byte address, equal to the PC.
- `rom_data_i`  in  32  combinational ROM read data for `rom_addr_o`.
- `id_pc_o`  out  32  PC of the instruction held in IF/ID.
- `id_inst_o`  out  32  instruction held in IF/ID.
- `id_valid_o`  out  1  IF/ID holds a real instruction.
- `id_in_delay_slot_o`  out  1  the IF/ID instruction sits in a branch delay slot.

## Operation
- FSM states:
  - `S_RESET`: `rom_ce_o=0`, PC=`RESET_PC`.
  - `S_RUN`: fetch.
  - `S_HOLD`: `stall_i[0]` asserted; PC frozen, `rom_ce_o` stays 1.
- FSM transitions:
  - `rst` → `S_RESET` from any state.
  - `S_RESET` → `S_RUN` on the first edge with `rst=0`.
  - `S_RUN` ↔ `S_HOLD` follows `stall_i[0]`.
- Next-PC priority, highest first:
  1. `rst`
  2. `flush_i` → `flush_pc_i`
  3. `stall_i[0]` → hold
  4. `branch_flag_i` → `{branch_target_i[31:2],2'b00}`
  5. otherwise PC+4, modulo 2^32 (`32'hFFFFFFFC` wraps to 0).
- PC advances only while `rom_ce_o=1`.
- IF/ID update priority, highest first:
  1. `rst` or `flush_i` → PC=0, inst=0 (nop), valid=0, delay-slot=0.
  2. `stall_i[1]` with `stall_i[0]=0` → insert bubble (valid=0, inst=0).
  3. `stall_i[1]` → hold.
  4. `rom_ce_o=0` → bubble.
  5. Otherwise capture `{PC, rom_data_i}` with valid=1.
- Delay slot: on the edge where `branch_flag_i=1` is accepted (not stalled, no flush), the captured word (branch PC+4) gets `id_in_delay_slot_o=1`. The flag clears on the next capture.
- A branch whose own delay-slot flag is set is honoured normally; there is no special case.
- Decode holds `branch_flag_i` for as long as its instruction is stalled. A branch is accepted exactly once.

## Timing
- Reset values of all outputs: `rom_ce_o=0`, `rom_addr_o=RESET_PC`, `id_pc_o=0`, `id_inst_o=0`, `id_valid_o=0`, `id_in_delay_slot_o=0`.
- Fetch latency:
  - First edge after `rst` falls: `rom_ce_o=1`, address `RESET_PC`.
  - That word appears on the `id_*` outputs one edge later.
- Throughput: one instruction per cycle.
- Branch redirect cost: zero bubbles with delay slots enabled.
- Simultaneous events: `flush_i` beats `branch_flag_i` and stall. `rst` beats everything.
- Reset mid-operation: all state returns to reset values on that edge. Any in-flight branch is dropped.

## Configuration
- `DELAY_SLOT_EN` defined: MIPS delay-slot semantics as described above.
- `DELAY_SLOT_EN` undefined:
  - On accepted branch, the word fetched that cycle is squashed (IF/ID bubble: valid=0, inst=0), costing one cycle.
  - `id_in_delay_slot_o` is tied to 0.

## Structure
- Shared defines header or package:
  - `ZeroWord`, `NopInst`
  - instruction address and data widths
  - stall bus width
  - FSM state encoding
- Sub-module `if_id_reg`: the IF/ID register with its flush, bubble and hold priority logic.
- The top level holds the PC, the FSM and next-PC selection.

## Test plan
- Reset: hold `rst` for 10 cycles → `rom_ce_o=0`, all `id_*` outputs zero. Release → PC sequence 0x0, 0x4, 0x8 on consecutive edges; `id_pc_o` lags the PC by one cycle.
- Jump with delay slot: `branch_flag_i=1`, target `0x00000040`, while ID holds PC 0x24 → IF/ID gets PC 0x28 with delay-slot=1, then PC 0x40 with delay-slot=0.
- Same jump with `DELAY_SLOT_EN` undefined → IF/ID becomes a bubble, then PC 0x40.
- Stall: `stall_i=2'b11` for 3 cycles at PC 0x10 → PC and IF/ID frozen. With `stall_i=2'b10` → bubble inserted while the PC advances.
- Flush plus branch in the same cycle, `flush_pc_i=0x20` → PC=0x20, IF/ID cleared, branch ignored.
- Wrap and alignment:
  - PC at `0xFFFFFFFC` advances to `0x0`.
  - Branch target `0x43` loads `0x40`.
  - `rst` asserted mid-stall → all outputs return to reset values.
